integ_dump: RTL and testbench
=============================

INTEG_DUMP -- requirements
Module: integ_dump

Interface
REQ-001 Parameter NCH, default 3, meaning correlator channel count (early/prompt/late).
REQ-002 Parameter IN_W, default 2, meaning signed two's-complement sample width.
REQ-003 Parameter ACC_W, default 32, meaning signed accumulator and sum width per channel.
REQ-004 Parameter CNT_W, default 16, meaning epoch sample-counter width.
REQ-005 Port clk  input  1  sole clock; all logic on rising edge.
REQ-006 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 Port sample_valid  input  1  sample qualifier.
REQ-008 Port sample  input  IN_W  signed sample, common to all channels.
REQ-009 Port chip  input  NCH  per-channel code chip; 0 adds sample, 1 subtracts sample.
REQ-010 Port dump  input  1  epoch flag, any duty cycle; only its rising edge is used.
REQ-011 Port sum  output  NCH*ACC_W  latched epoch sums, channel k at bits [k*ACC_W +: ACC_W].
REQ-012 Port sum_cnt  output  CNT_W  number of valid samples in the latched epoch.
REQ-013 Port sat  output  NCH  per-channel saturation-occurred flag for the latched epoch.
REQ-014 Port sum_valid / sum_ready  output / input  1 / 1  valid-ready handshake on the sum, sum_cnt and sat outputs.
REQ-015 Port overrun  output  1  sticky flag: an unacknowledged result was overwritten.

Function
REQ-016 dump_q SHALL register dump each cycle; dump_edge = dump & ~dump_q.
REQ-017 Each channel SHALL have a contribution of +sample when chip[k]=0 and -sample when chip[k]=1, sign-extended to ACC_W+1 bits; the contribution SHALL be 0 when sample_valid=0.
REQ-018 On a non-edge cycle, each accumulator SHALL take the value acc+contribution, and the counter SHALL increment on sample_valid.
REQ-019 On a dump_edge cycle, sum SHALL load acc+contribution, so the current sample is included; acc SHALL clear to 0; sum_cnt SHALL load cnt+sample_valid; cnt SHALL clear to 0.
REQ-020 sum_valid SHALL rise on the clock edge that latches the result, i.e. one cycle of latency after the dump_edge cycle.
REQ-021 sum_valid SHALL hold, and sum/sum_cnt/sat SHALL stay stable, until a cycle with sum_valid&sum_ready, after which sum_valid SHALL drop.
REQ-022 If dump_edge and sum_valid&sum_ready occur in the same cycle, the new result SHALL load, sum_valid SHALL stay 1, and overrun SHALL be unchanged.
REQ-023 If dump_edge occurs while sum_valid=1 and sum_ready=0, the new result SHALL overwrite the old one and overrun SHALL set.
REQ-024 The counter SHALL saturate at 2^CNT_W-1 and SHALL not wrap.
REQ-025 A dump that is held high for many cycles SHALL produce exactly one result.
REQ-026 The output-side state machine SHALL have two states: EMPTY and FULL, transitioning per REQ-020 to REQ-023.

Reset
REQ-027 While rst_n=0, the following SHALL be 0 asynchronously: acc, cnt, dump_q, sum, sum_cnt, sat, sum_valid and overrun; the state SHALL be EMPTY.
REQ-028 A reset asserted mid-epoch SHALL discard partial sums, and no result SHALL be emitted for that epoch.
REQ-029 After release, the first dump_edge SHALL require dump to go low-to-high after dump_q has sampled 0.

Configuration
REQ-030 With INTEG_DUMP_SAT_EN defined, each accumulator SHALL clamp at +(2^(ACC_W-1)-1) and -2^(ACC_W-1); a per-channel sticky bit SHALL set on any clamp in the epoch and SHALL transfer to sat on dump.
REQ-031 Without INTEG_DUMP_SAT_EN, accumulators SHALL wrap modulo 2^ACC_W and sat SHALL be tied to 0.

Structure
REQ-032 The shared package gps_pkg SHALL hold the default IN_W, ACC_W, CNT_W and NCH constants and a chip-sign enum (CHIP_ADD=0, CHIP_SUB=1).
REQ-033 Per-channel accumulate, saturation and dump logic SHALL live in sub-module integ_dump_ch, generated NCH times; the handshake FSM and counter SHALL live in the top level.

Verification
REQ-034 NCH=3, IN_W=2; 10 valid samples of +1 with chip=3'b010, then a dump edge -> sum = {+10,-10,+10} (ch0..ch2 = +10, -10, +10), sum_cnt=10, sum_valid one cycle after the edge cycle.
REQ-035 sample_valid low for 4 of 10 cycles, sample=-2, chip=0, then dump -> sum=-12 on all channels, sum_cnt=6.
REQ-036 sum_ready=0 across two dump edges -> second result visible, overrun=1; dump edge while sum_ready=1 on a pending result -> sum_valid stays 1, overrun unchanged.
REQ-037 dump held high for 50 cycles -> exactly one sum_valid assertion; rst_n pulsed low mid-epoch -> all outputs 0 immediately, and the next epoch counts from 0.
REQ-038 ACC_W=4, sample=+1, chip=0, 9 samples, then dump -> with INTEG_DUMP_SAT_EN: sum=+7 and sat=3'b111; without it: sum=-7 and sat=0.

Source files
------------

// File: rtl/gps_pkg.sv
// gps_pkg: shared constants and types for the GPS correlator front end.
//   NCH_DEF / IN_W_DEF / ACC_W_DEF / CNT_W_DEF : default channel count and widths
//   chip_sign_e : code chip polarity (CHIP_ADD adds the sample, CHIP_SUB subtracts it)
//   out_state_e : result-register occupancy of the integrate-and-dump block
package gps_pkg;
    localparam int NCH_DEF   = 3;
    localparam int IN_W_DEF  = 2;
    localparam int ACC_W_DEF = 32;
    localparam int CNT_W_DEF = 16;

    typedef enum logic {
        CHIP_ADD = 1'b0,
        CHIP_SUB = 1'b1
    } chip_sign_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;
endpackage

// File: rtl/integ_dump_ch.sv
// integ_dump_ch: one correlator channel -- accumulates +/-sample per code chip
// and transfers the running sum to its output register on a dump edge.
// Optional clamping with sticky saturation flag under INTEG_DUMP_SAT_EN;
// otherwise the accumulator wraps and sat is tied low.
//   clk, rst_n      : clock, async active-low reset
//   sample_valid    : sample qualifier
//   sample          : signed input sample
//   chip            : 0 add, 1 subtract
//   dump_edge       : end-of-epoch strobe (one cycle)
//   sum             : latched epoch sum
//   sat             : a clamp happened during the latched epoch
module integ_dump_ch
    import gps_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_valid,
    input  logic signed [IN_W-1:0]  sample,
    input  logic                    chip,
    input  logic                    dump_edge,
    output logic signed [ACC_W-1:0] sum,
    output logic                    sat
);
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W:0]   ext;
    logic signed [ACC_W:0]   contrib;
    logic signed [ACC_W:0]   raw;
    logic signed [ACC_W-1:0] nxt;

    always_comb begin
        ext     = {{(ACC_W+1-IN_W){sample[IN_W-1]}}, sample};
        contrib = '0;
        if (sample_valid)
            contrib = (chip_sign_e'(chip) == CHIP_SUB) ? -ext : ext;
        // One guard bit: acc plus a narrow sample always fits in ACC_W+1 bits.
        raw = {acc[ACC_W-1], acc} + contrib;
    end

`ifdef INTEG_DUMP_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic clamp;
    logic sticky;

    always_comb begin
        clamp = 1'b0;
        nxt   = raw[ACC_W-1:0];
        // Guard bit disagreeing with the sign bit means the sum left ACC_W range.
        if (raw[ACC_W] != raw[ACC_W-1]) begin
            clamp = 1'b1;
            nxt   = raw[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            sticky <= 1'b0;
            sum    <= '0;
            sat    <= 1'b0;
        end else if (dump_edge) begin
            sum    <= nxt;
            sat    <= sticky | clamp;
            acc    <= '0;
            sticky <= 1'b0;
        end else begin
            acc    <= nxt;
            sticky <= sticky | clamp;
        end
    end
`else
    logic unused_guard;
    assign unused_guard = raw[ACC_W];
    assign nxt          = raw[ACC_W-1:0];
    assign sat          = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            sum <= '0;
        end else if (dump_edge) begin
            sum <= nxt;
            acc <= '0;
        end else begin
            acc <= nxt;
        end
    end
`endif
endmodule

// File: rtl/integ_dump.sv
// integ_dump: NCH-channel integrate-and-dump correlator with a valid/ready
// result register. A rising edge on dump closes the epoch (current sample
// included); the result appears one cycle later and is held until accepted.
// Overwriting an unaccepted result sets the sticky overrun flag.
// Optional accumulator clamping: define INTEG_DUMP_SAT_EN.
//   clk, rst_n          : clock, async active-low reset
//   sample_valid/sample : qualified signed sample, shared by all channels
//   chip[NCH]           : per-channel code chip (0 add, 1 subtract)
//   dump                : epoch flag, rising edge used
//   sum[NCH*ACC_W]      : epoch sums, channel k at [k*ACC_W +: ACC_W]
//   sum_cnt             : valid samples in the latched epoch
//   sat[NCH]            : per-channel saturation flags for the latched epoch
//   sum_valid/sum_ready : result handshake
//   overrun             : sticky, result overwritten before acceptance
module integ_dump
    import gps_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sample_valid,
    input  logic signed [IN_W-1:0] sample,
    input  logic [NCH-1:0]         chip,
    input  logic                   dump,
    output logic [NCH*ACC_W-1:0]   sum,
    output logic [CNT_W-1:0]       sum_cnt,
    output logic [NCH-1:0]         sat,
    output logic                   sum_valid,
    input  logic                   sum_ready,
    output logic                   overrun
);
    logic             dump_q;
    logic             dump_edge;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    out_state_e       state_q, state_d;
    logic             overrun_d;

    assign dump_edge = dump & ~dump_q;

    // Saturating count; at all-ones it simply holds.
    assign cnt_inc = (sample_valid && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dump_q  <= 1'b0;
            cnt     <= '0;
            sum_cnt <= '0;
        end else begin
            dump_q <= dump;
            if (dump_edge) begin
                sum_cnt <= cnt_inc;
                cnt     <= '0;
            end else begin
                cnt <= cnt_inc;
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        integ_dump_ch #(
            .IN_W  (IN_W),
            .ACC_W (ACC_W)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .sample_valid (sample_valid),
            .sample       (sample),
            .chip         (chip[k]),
            .dump_edge    (dump_edge),
            .sum          (sum[k*ACC_W +: ACC_W]),
            .sat          (sat[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            overrun <= overrun_d;
        end
    end

    // A new result always wins; it only counts as an overrun when the
    // pending one is neither accepted this cycle nor already gone.
    always_comb begin
        state_d   = state_q;
        overrun_d = overrun;
        case (state_q)
            ST_EMPTY: begin
                if (dump_edge) state_d = ST_FULL;
            end
            ST_FULL: begin
                if (dump_edge) begin
                    state_d = ST_FULL;
                    if (!sum_ready) overrun_d = 1'b1;
                end else if (sum_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    assign sum_valid = (state_q == ST_FULL);
endmodule

// File: tb/tb_integ_dump.sv
module tb_integ_dump;
    localparam int NCH   = 3;
    localparam int IN_W  = 2;
    localparam int ACC_W = 32;
    localparam int CNT_W = 16;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   sample_valid = 1'b0;
    logic signed [IN_W-1:0] sample = '0;
    logic [NCH-1:0]         chip = '0;
    logic                   dump = 1'b0;
    logic                   sum_ready = 1'b0;

    logic [NCH*ACC_W-1:0]   sum;
    logic [CNT_W-1:0]       sum_cnt;
    logic [NCH-1:0]         sat;
    logic                   sum_valid, overrun;

    logic [NCH*4-1:0]       sum4;
    logic [CNT_W-1:0]       sum_cnt4;
    logic [NCH-1:0]         sat4;
    logic                   sum_valid4, overrun4;

    always #5 clk = ~clk;

    integ_dump #(.NCH(NCH), .IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
        .chip(chip), .dump(dump), .sum(sum), .sum_cnt(sum_cnt), .sat(sat),
        .sum_valid(sum_valid), .sum_ready(sum_ready), .overrun(overrun));

    integ_dump #(.NCH(NCH), .IN_W(IN_W), .ACC_W(4), .CNT_W(CNT_W)) dut4 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
        .chip(chip), .dump(dump), .sum(sum4), .sum_cnt(sum_cnt4), .sat(sat4),
        .sum_valid(sum_valid4), .sum_ready(sum_ready), .overrun(overrun4));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model (main instance) ----------------
    localparam longint AMAX = (longint'(1) <<< (ACC_W-1)) - 1;
    localparam longint AMIN = -(longint'(1) <<< (ACC_W-1));
    localparam longint CMAX = (longint'(1) <<< CNT_W) - 1;

    function automatic longint wrapw(input longint v, input int w);
        longint m = longint'(1) <<< w;
        longint r = v % m;
        if (r < 0) r += m;
        if (r >= m/2) r -= m;
        return r;
    endfunction

    longint m_acc [NCH];
    bit     m_stk [NCH];
    longint m_cnt;
    bit     m_dq;
    bit     m_valid, m_ovr;
    longint m_sum [NCH];
    longint m_scnt;
    bit     m_sat [NCH];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                m_acc[k] = 0; m_stk[k] = 0; m_sum[k] = 0; m_sat[k] = 0;
            end
            m_cnt = 0; m_dq = 0; m_valid = 0; m_ovr = 0; m_scnt = 0;
        end else begin
            bit     edge_now;
            longint nv [NCH];
            bit     cl [NCH];
            longint ncnt;
            edge_now = dump && !m_dq;
            m_dq     = dump;
            for (int k = 0; k < NCH; k++) begin
                longint c;
                c = sample_valid ? (chip[k] ? -longint'(sample) : longint'(sample)) : 0;
                nv[k] = m_acc[k] + c;
                cl[k] = 0;
`ifdef INTEG_DUMP_SAT_EN
                if (nv[k] > AMAX) begin nv[k] = AMAX; cl[k] = 1; end
                if (nv[k] < AMIN) begin nv[k] = AMIN; cl[k] = 1; end
`else
                nv[k] = wrapw(nv[k], ACC_W);
`endif
            end
            ncnt = m_cnt + (sample_valid ? 1 : 0);
            if (ncnt > CMAX) ncnt = CMAX;
            if (edge_now) begin
                if (m_valid && !sum_ready) m_ovr = 1;
                for (int k = 0; k < NCH; k++) begin
                    m_sum[k] = nv[k]; m_sat[k] = m_stk[k] | cl[k];
                    m_acc[k] = 0;     m_stk[k] = 0;
                end
                m_scnt  = ncnt;
                m_cnt   = 0;
                m_valid = 1;
            end else begin
                for (int k = 0; k < NCH; k++) begin
                    m_acc[k] = nv[k]; m_stk[k] = m_stk[k] | cl[k];
                end
                m_cnt = ncnt;
                if (m_valid && sum_ready) m_valid = 0;
            end
        end
    end

    // Compare on the falling edge, away from the active edge.
    always @(negedge clk) begin
        chk("model_sum_valid", longint'(sum_valid), longint'(m_valid));
        chk("model_overrun", longint'(overrun), longint'(m_ovr));
        if (m_valid) begin
            for (int k = 0; k < NCH; k++) begin
                chk($sformatf("model_sum_ch%0d", k), longint'($signed(sum[k*ACC_W +: ACC_W])), m_sum[k]);
                chk($sformatf("model_sat_ch%0d", k), longint'(sat[k]), longint'(m_sat[k]));
            end
            chk("model_sum_cnt", longint'(sum_cnt), m_scnt);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit v, input int s, input logic [NCH-1:0] c, input bit d, input bit r);
        sample_valid = v;
        sample       = IN_W'(s);
        chip         = c;
        dump         = d;
        sum_ready    = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        dump  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    int  rises;
    bit  prev_v;

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum_valid", longint'(sum_valid), 0);
        chk("rst_sum", longint'(sum[31:0]), 0);
        chk("rst_overrun", longint'(overrun), 0);
        rst_n = 1'b1;

        // Ten +1 samples, chip 010, then an empty dump-edge cycle.
        for (int i = 0; i < 10; i++) cyc(1, 1, 3'b010, 0, 0);
        chk("t1_pre_valid", longint'(sum_valid), 0);
        cyc(0, 0, 3'b000, 1, 0);
        chk("t1_valid", longint'(sum_valid), 1);
        chk("t1_ch0", longint'($signed(sum[31:0])), 10);
        chk("t1_ch1", longint'($signed(sum[63:32])), -10);
        chk("t1_ch2", longint'($signed(sum[95:64])), 10);
        chk("t1_cnt", longint'(sum_cnt), 10);
        cyc(0, 0, 3'b000, 0, 1);
        chk("t1_ack", longint'(sum_valid), 0);

        // -2 with four invalid cycles out of ten.
        for (int i = 0; i < 10; i++)
            cyc(!(i == 1 || i == 4 || i == 6 || i == 8), -2, 3'b000, 0, 0);
        cyc(0, 0, 3'b000, 1, 0);
        chk("t2_ch0", longint'($signed(sum[31:0])), -12);
        chk("t2_ch2", longint'($signed(sum[95:64])), -12);
        chk("t2_cnt", longint'(sum_cnt), 6);

        // Dump edge together with acceptance of the pending result.
        cyc(0, 0, 3'b000, 0, 0);
        cyc(1, 1, 3'b000, 1, 1);
        chk("t3_same_valid", longint'(sum_valid), 1);
        chk("t3_same_ovr", longint'(overrun), 0);
        chk("t3_same_sum", longint'($signed(sum[31:0])), 1);
        // Dump edge without acceptance: overwrite and overrun.
        cyc(1, 1, 3'b000, 0, 0);
        cyc(1, 1, 3'b000, 1, 0);
        chk("t3_ovr", longint'(overrun), 1);
        chk("t3_ovr_sum", longint'($signed(sum[31:0])), 2);
        chk("t3_ovr_cnt", longint'(sum_cnt), 2);

        // Reset mid-epoch: outputs clear at once, next epoch starts from 0.
        cyc(1, 1, 3'b000, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 3'b000, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", longint'(sum_valid), 0);
        chk("mid_rst_ovr", longint'(overrun), 0);
        chk("mid_rst_sum", longint'(sum[31:0]), 0);
        chk("mid_rst_cnt", longint'(sum_cnt), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1, 1, 3'b111, 0, 0);
        cyc(0, 0, 3'b000, 1, 0);
        chk("post_rst_cnt", longint'(sum_cnt), 3);
        chk("post_rst_ch1", longint'($signed(sum[63:32])), -3);
        cyc(0, 0, 3'b000, 0, 1);

        // Dump held high for 50 cycles yields one result.
        rises  = 0;
        prev_v = sum_valid;
        for (int i = 0; i < 50; i++) begin
            cyc(1, 1, 3'b000, 1, 1);
            if (sum_valid && !prev_v) rises++;
            prev_v = sum_valid;
        end
        cyc(0, 0, 3'b000, 0, 1);
        chk("held_dump_results", longint'(rises), 1);

        // Narrow accumulator: nine +1 samples into a 4-bit sum.
        do_reset();
        for (int i = 0; i < 9; i++) cyc(1, 1, 3'b000, 0, 0);
        cyc(0, 0, 3'b000, 1, 0);
        chk("acc4_valid", longint'(sum_valid4), 1);
        chk("acc32_ch0", longint'($signed(sum[31:0])), 9);
`ifdef INTEG_DUMP_SAT_EN
        chk("acc4_ch0", longint'($signed(sum4[3:0])), 7);
        chk("acc4_ch2", longint'($signed(sum4[11:8])), 7);
        chk("acc4_sat", longint'(sat4), 7);
`else
        chk("acc4_ch0", longint'($signed(sum4[3:0])), -7);
        chk("acc4_ch2", longint'($signed(sum4[11:8])), -7);
        chk("acc4_sat", longint'(sat4), 0);
`endif
        cyc(0, 0, 3'b000, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
